// File: rtl/button_conditioner_if.sv
// Button conditioner signal bundle: raw button in, conditioned outputs back.
// The master side drives the raw button; the slave side is the conditioner.
interface button_conditioner_if;
    logic btn_in;
    logic level;
    logic pulse;
    logic repeating;

    modport master (
        output btn_in,
        input  level,
        input  pulse,
        input  repeating
    );

    modport slave (
        input  btn_in,
        output level,
        output pulse,
        output repeating
    );
endinterface

// File: rtl/button_conditioner.sv
// Push-button conditioner: two-flop synchroniser, press/release debounce,
// one-cycle press strobe and optional auto-repeat strobes while held.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000,
    parameter int CNT_W           = 26
) (
    input  logic                 ck,
    input  logic                 reset,
    button_conditioner_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        REPEAT,
        RELEASE_WAIT
    } state_e;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam bit               RPT_EN  = (REPEAT_DELAY != 0);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] dc_q, dc_d;
    logic [CNT_W-1:0] hc_q, hc_d;
    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;
    logic             repeating_q, repeating_d;
    logic             btn_s;

    assign btn_s         = s2_q;
    assign bus.level     = level_q;
    assign bus.pulse     = pulse_q;
    assign bus.repeating = repeating_q;

    // State, counters, synchroniser and registered outputs.
    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            dc_q        <= '0;
            hc_q        <= '0;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            level_q     <= 1'b0;
            pulse_q     <= 1'b0;
            repeating_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dc_q        <= dc_d;
            hc_q        <= hc_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            level_q     <= level_d;
            pulse_q     <= pulse_d;
            repeating_q <= repeating_d;
        end
    end

    // Next state: debounce both edges; a release beats a repeat strobe.
    always_comb begin
        state_d = state_q;
        dc_d    = dc_q;
        hc_d    = hc_q;
        pulse_d = 1'b0;
        s1_d    = bus.btn_in;
        s2_d    = s1_q;

        unique case (state_q)
            IDLE: begin
                if (btn_s) begin
                    dc_d    = ONE;
                    state_d = PRESS_WAIT;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d = IDLE;
                end else if (dc_q == DB_LAST) begin
                    state_d = HELD;
                    pulse_d = 1'b1;
                    hc_d    = '0;
                end else begin
                    dc_d = dc_q + ONE;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    dc_d    = ONE;
                    state_d = RELEASE_WAIT;
                end else if (RPT_EN && hc_q == RD_LAST) begin
                    state_d = REPEAT;
                    pulse_d = 1'b1;
                    hc_d    = '0;
                end else if (RPT_EN) begin
                    // With repeat disabled hc stays parked so it cannot wrap.
                    hc_d = hc_q + ONE;
                end
            end
            REPEAT: begin
                if (!btn_s) begin
                    dc_d    = ONE;
                    state_d = RELEASE_WAIT;
                end else if (hc_q == RP_LAST) begin
                    pulse_d = 1'b1;
                    hc_d    = '0;
                end else begin
                    hc_d = hc_q + ONE;
                end
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_d = HELD;
                    hc_d    = '0;
                end else if (dc_q == DB_LAST) begin
                    state_d = IDLE;
                end else begin
                    dc_d = dc_q + ONE;
                end
            end
            default: begin
                state_d = IDLE;
                dc_d    = '0;
                hc_d    = '0;
            end
        endcase
    end

    // Level and repeating follow the state being entered, so they stay registered.
    always_comb begin
        level_d     = (state_d == HELD) ||
                      (state_d == REPEAT) ||
                      (state_d == RELEASE_WAIT);
        repeating_d = (state_d == REPEAT);
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: two instances (repeat on / repeat off),
// per-edge expected outputs queued at drive time and compared after the edge.
module tb_button_conditioner;

    logic ck;
    logic reset;
    int   n_chk;
    int   n_pass;

    logic [2:0] sb_q[$];

    button_conditioner_if ifa ();
    button_conditioner_if ifb ();

    button_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3),
        .CNT_W          (8)
    ) u_dut_a (
        .ck   (ck),
        .reset(reset),
        .bus  (ifa)
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (0),
        .REPEAT_PERIOD  (3),
        .CNT_W          (8)
    ) u_dut_b (
        .ck   (ck),
        .reset(reset),
        .bus  (ifb)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic chk(input string tag, input logic [2:0] got,
                       input logic [2:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got {level,pulse,rep}=%b exp=%b", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] outs(input bit sel);
        if (sel)
            return {ifb.level, ifb.pulse, ifb.repeating};
        return {ifa.level, ifa.pulse, ifa.repeating};
    endfunction

    // Drive btn for the next edge, queue the outputs expected after it.
    task automatic drive(input bit sel, input logic b, input logic l,
                         input logic p, input logic r, input string tag);
        logic [2:0] exp;
        if (sel) ifb.btn_in = b;
        else     ifa.btn_in = b;
        sb_q.push_back({l, p, r});
        @(posedge ck);
        #1;
        exp = sb_q.pop_front();
        chk(tag, outs(sel), exp);
    endtask

    // Async reset between edges: outputs must clear with no clock edge.
    task automatic pulse_reset(input string tag);
        reset = 1'b1;
        #1;
        chk({tag, " a"}, outs(1'b0), 3'b000);
        chk({tag, " b"}, outs(1'b1), 3'b000);
        #1;
        reset = 1'b0;
    endtask

    // Fresh press held 8 edges then released: press at 5, release at 13.
    task automatic press_after_reset(input string t);
        for (int k = 0; k < 18; k++)
            drive(0, k < 8, k >= 5 && k <= 12, k == 5, 1'b0,
                  $sformatf("%s e%0d", t, k));
    endtask

    initial begin
        n_chk      = 0;
        n_pass     = 0;
        reset      = 1'b1;
        ifa.btn_in = 1'b0;
        ifb.btn_in = 1'b0;
        repeat (3) @(posedge ck);
        #1;
        chk("rst a", outs(1'b0), 3'b000);
        chk("rst b", outs(1'b1), 3'b000);
        reset = 1'b0;

        // Clean press held 20 edges: repeat at 15, 18, 21; release seen at 22.
        for (int k = 0; k < 30; k++)
            drive(0, k < 20, k >= 5 && k <= 24,
                  k == 5 || k == 15 || k == 18 || k == 21,
                  k >= 15 && k <= 21, $sformatf("t1 e%0d", k));

        // Three-cycle glitch is rejected.
        for (int k = 0; k < 15; k++)
            drive(0, k < 3, 1'b0, 1'b0, 1'b0, $sformatf("t2 e%0d", k));

        // Release bounce 0,0,1,0...: level holds until 4 synced lows (edge 16).
        for (int k = 0; k < 24; k++)
            drive(0, k < 8 || k == 10, k >= 5 && k <= 15, k == 5, 1'b0,
                  $sformatf("t3 e%0d", k));

        // Long hold: repeats every 3 from 15; release at 42 beats the strobe.
        for (int k = 0; k < 50; k++)
            drive(0, k < 40, k >= 5 && k <= 44,
                  k == 5 || (k >= 15 && k <= 39 && (k - 15) % 3 == 0),
                  k >= 15 && k <= 41, $sformatf("t4 e%0d", k));

        // Reset mid PRESS_WAIT, then a fresh full-latency press.
        for (int k = 0; k < 4; k++)
            drive(0, 1'b1, 1'b0, 1'b0, 1'b0, $sformatf("t5a e%0d", k));
        pulse_reset("t5a rst");
        press_after_reset("t5a post");

        // Reset mid REPEAT, button kept high across reset.
        for (int k = 0; k < 20; k++)
            drive(0, 1'b1, k >= 5, k == 5 || k == 15 || k == 18, k >= 15,
                  $sformatf("t5b e%0d", k));
        pulse_reset("t5b rst");
        press_after_reset("t5b post");

        // Repeat disabled: 100-cycle hold gives one pulse only.
        for (int k = 0; k < 110; k++)
            drive(1, k < 100, k >= 5 && k <= 104, k == 5, 1'b0,
                  $sformatf("t6 e%0d", k));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
